// File: rtl/ff_bank_pkg.sv
// Shared mode encodings and helpers for the multi-mode flip-flop bank.
// The optional error counter is controlled by the FF_BANK_ERRCNT_EN macro in the top level.
package ff_bank_pkg;

    localparam logic [1:0] MODE_RS_ENC = 2'd0;
    localparam logic [1:0] MODE_JK_ENC = 2'd1;
    localparam logic [1:0] MODE_D_ENC  = 2'd2;
    localparam logic [1:0] MODE_T_ENC  = 2'd3;

    typedef enum logic [1:0] {
        MODE_RS = MODE_RS_ENC,
        MODE_JK = MODE_JK_ENC,
        MODE_D  = MODE_D_ENC,
        MODE_T  = MODE_T_ENC
    } mode_e;

    // S=R=1 is only a fault in RS mode; JK treats it as toggle.
    function automatic logic is_illegal(input mode_e m, input logic s, input logic r);
        return (m == MODE_RS) && s && r;
    endfunction

endpackage

// File: rtl/ff_bank_cell.sv
// One storage channel of the bank: RS / JK / D / T behaviour selected by mode,
// with registered complementary output and a registered illegal-input pulse.
module ff_bank_cell
    import ff_bank_pkg::*;
#(
    parameter logic INIT = 1'b0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       s,
    input  logic       r,
    output logic       q,
    output logic       q_bar,
    output logic       illegal
);

    mode_e mode_sel;
    logic  q_next;
    logic  illegal_next;

    assign mode_sel = mode_e'(mode);

    always_comb begin
        q_next       = q;
        illegal_next = 1'b0;
        if (en) begin
            case (mode_sel)
                MODE_RS: begin
                    if (is_illegal(mode_sel, s, r)) illegal_next = 1'b1;
                    else if (s)                     q_next = 1'b1;
                    else if (r)                     q_next = 1'b0;
                end
                MODE_JK: begin
                    if (s && r)  q_next = ~q;
                    else if (s)  q_next = 1'b1;
                    else if (r)  q_next = 1'b0;
                end
                MODE_D: begin
                    q_next = s;
                end
                MODE_T: begin
                    if (s) q_next = ~q;
                end
                default: begin
                    q_next = q;
                end
            endcase
        end
    end

    // q_bar is its own flop loaded with ~q_next so both outputs switch on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q       <= INIT;
            q_bar   <= ~INIT;
            illegal <= 1'b0;
        end else begin
            q       <= q_next;
            q_bar   <= ~q_next;
            illegal <= illegal_next;
        end
    end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH multi-mode flag flops with sticky illegal-input reporting.
// Define FF_BANK_ERRCNT_EN to add the saturating err_count port and counter.
module multi_mode_ff_bank
    import ff_bank_pkg::*;
#(
    parameter int unsigned       WIDTH = 8,
    parameter logic [WIDTH-1:0]  INIT  = {WIDTH{1'b0}},
    parameter int unsigned       CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] set_in,
    input  logic [WIDTH-1:0] clr_in,
    input  logic             clear_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] illegal,
    output logic             err_sticky
`ifdef FF_BANK_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] err_count
`endif
);

    logic any_illegal_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_bank_cell #(
            .INIT (INIT[i])
        ) u_cell (
            .clock   (clock),
            .reset_n (reset_n),
            .en      (en),
            .mode    (mode),
            .s       (set_in[i]),
            .r       (clr_in[i]),
            .q       (q[i]),
            .q_bar   (q_bar[i]),
            .illegal (illegal[i])
        );
    end

    // Same condition the cells register into illegal, seen one edge early.
    assign any_illegal_next = en && (mode_e'(mode) == MODE_RS) && (|(set_in & clr_in));

    // A new event wins over a simultaneous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky <= 1'b0;
        end else begin
            err_sticky <= (err_sticky & ~clear_err) | any_illegal_next;
        end
    end

`ifdef FF_BANK_ERRCNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (clear_err) begin
            err_count <= any_illegal_next ? CNT_W'(1) : '0;
        end else if (any_illegal_next && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end
`else
    logic [CNT_W-1:0] cnt_w_unused;
    assign cnt_w_unused = '0;
`endif

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Self-checking bench for multi_mode_ff_bank against a per-bit behavioural model.
// Counter checks are active when FF_BANK_ERRCNT_EN is defined.
module tb_multi_mode_ff_bank;

    localparam int         W       = 8;
    localparam logic [7:0] INIT    = 8'hA5;
    localparam int         CW      = 2;
    localparam int         CNT_MAX = (1 << CW) - 1;

    logic         clock;
    logic         reset_n;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] set_in;
    logic [W-1:0] clr_in;
    logic         clear_err;
    logic [W-1:0] q;
    logic [W-1:0] q_bar;
    logic [W-1:0] illegal;
    logic         err_sticky;
`ifdef FF_BANK_ERRCNT_EN
    logic [CW-1:0] err_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_q;
    logic [W-1:0] m_ill;
    logic         m_sticky;
    int           m_cnt;

    multi_mode_ff_bank #(
        .WIDTH (W),
        .INIT  (INIT),
        .CNT_W (CW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .en         (en),
        .mode       (mode),
        .set_in     (set_in),
        .clr_in     (clr_in),
        .clear_err  (clear_err),
        .q          (q),
        .q_bar      (q_bar),
        .illegal    (illegal),
        .err_sticky (err_sticky)
`ifdef FF_BANK_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and move the reference model by the same rules.
    task automatic tick();
        logic [W-1:0] nq;
        logic [W-1:0] nill;
        logic         any;
        @(posedge clock);
        if (!reset_n) begin
            m_q = INIT; m_ill = '0; m_sticky = 1'b0; m_cnt = 0;
        end else begin
            nq   = m_q;
            nill = '0;
            if (en) begin
                for (int i = 0; i < W; i++) begin
                    case (mode)
                        2'd0: if (set_in[i] && clr_in[i]) nill[i] = 1'b1;
                              else if (set_in[i]) nq[i] = 1'b1;
                              else if (clr_in[i]) nq[i] = 1'b0;
                        2'd1: if (set_in[i] && clr_in[i]) nq[i] = ~m_q[i];
                              else if (set_in[i]) nq[i] = 1'b1;
                              else if (clr_in[i]) nq[i] = 1'b0;
                        2'd2: nq[i] = set_in[i];
                        default: if (set_in[i]) nq[i] = ~m_q[i];
                    endcase
                end
            end
            any      = |nill;
            m_sticky = (m_sticky && !clear_err) || any;
            if (clear_err)                    m_cnt = any ? 1 : 0;
            else if (any && m_cnt < CNT_MAX)  m_cnt = m_cnt + 1;
            m_q   = nq;
            m_ill = nill;
        end
        #1;
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] s,
                         input logic [7:0] r, input logic c);
        en = e; mode = m; set_in = s; clr_in = r; clear_err = c;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        drive(1'b1, 2'd0, 8'h00, 8'h00, 1'b0);
        #3 reset_n = 1'b0;
        m_q = INIT; m_ill = '0; m_sticky = 1'b0; m_cnt = 0;
        #1;
        total++; if (q !== 8'hA5) begin bad++; $display("FAIL reset_q got=%h exp=a5", q); end
        total++; if (q_bar !== 8'h5A) begin bad++; $display("FAIL reset_q_bar got=%h exp=5a", q_bar); end
        total++; if (illegal !== 8'h00) begin bad++; $display("FAIL reset_illegal got=%h exp=00", illegal); end
        total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%b exp=0", err_sticky); end
`ifdef FF_BANK_ERRCNT_EN
        total++; if (err_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", err_count); end
`endif
        tick(); tick();
        #2 reset_n = 1'b1;
    endtask

    task automatic test_rs();
        drive(1'b1, 2'd0, 8'h0F, 8'hF0, 1'b0);
        tick();
        total++; if (q !== 8'h0F) begin bad++; $display("FAIL rs_set got=%h exp=0f", q); end
        total++; if (q_bar !== 8'hF0) begin bad++; $display("FAIL rs_set_bar got=%h exp=f0", q_bar); end
        drive(1'b1, 2'd0, 8'h01, 8'h01, 1'b0);
        tick();
        total++; if (q !== 8'h0F) begin bad++; $display("FAIL rs_illegal_hold got=%h exp=0f", q); end
        total++; if (illegal !== 8'h01) begin bad++; $display("FAIL rs_illegal got=%h exp=01", illegal); end
        total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL rs_sticky got=%b exp=1", err_sticky); end
`ifdef FF_BANK_ERRCNT_EN
        total++; if (err_count !== 2'd1) begin bad++; $display("FAIL rs_count got=%0d exp=1", err_count); end
`endif
        drive(1'b1, 2'd0, 8'h00, 8'h00, 1'b0);
        tick();
        total++; if (illegal !== 8'h00) begin bad++; $display("FAIL rs_pulse_end got=%h exp=00", illegal); end
        total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL rs_sticky_hold got=%b exp=1", err_sticky); end
    endtask

    task automatic test_toggle();
        logic [7:0] exp_q [4] = '{8'hF0, 8'h0F, 8'h8F, 8'h0F};
        for (int k = 0; k < 4; k++) begin
            if (k < 2) drive(1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0);
            else       drive(1'b1, 2'd3, 8'h80, 8'h00, 1'b0);
            tick();
            total++; if (q !== exp_q[k]) begin bad++; $display("FAIL toggle_%0d got=%h exp=%h", k, q, exp_q[k]); end
            total++; if (illegal !== 8'h00) begin bad++; $display("FAIL toggle_ill_%0d got=%h exp=00", k, illegal); end
        end
    endtask

    task automatic test_enable_d();
        drive(1'b0, 2'd2, 8'h3C, 8'h00, 1'b0);
        tick();
        total++; if (q !== 8'h0F) begin bad++; $display("FAIL en_off_hold got=%h exp=0f", q); end
        drive(1'b0, 2'd0, 8'hFF, 8'hFF, 1'b0);
        tick();
        total++; if (illegal !== 8'h00) begin bad++; $display("FAIL en_off_no_illegal got=%h exp=00", illegal); end
        drive(1'b1, 2'd2, 8'h3C, 8'h00, 1'b0);
        tick();
        total++; if (q !== 8'h3C) begin bad++; $display("FAIL d_load got=%h exp=3c", q); end
        total++; if (q_bar !== 8'hC3) begin bad++; $display("FAIL d_load_bar got=%h exp=c3", q_bar); end
    endtask

    task automatic test_counter();
        int exp_c [5] = '{1, 2, 3, 3, 3};
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
        tick();
        total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL clr_en_off got=%b exp=0", err_sticky); end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'd0, 8'h01, 8'h01, 1'b0);
            tick();
            total++; if (illegal !== 8'h01) begin bad++; $display("FAIL sat_ill_%0d got=%h exp=01", k, illegal); end
`ifdef FF_BANK_ERRCNT_EN
            total++; if (int'(err_count) !== exp_c[k]) begin bad++; $display("FAIL sat_cnt_%0d got=%0d exp=%0d", k, err_count, exp_c[k]); end
`else
            if (exp_c[k] == 0) $display("unexpected zero");
`endif
        end
        drive(1'b1, 2'd0, 8'h10, 8'h10, 1'b1);
        tick();
        total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL clr_with_event_sticky got=%b exp=1", err_sticky); end
`ifdef FF_BANK_ERRCNT_EN
        total++; if (err_count !== 2'd1) begin bad++; $display("FAIL clr_with_event_cnt got=%0d exp=1", err_count); end
`endif
        drive(1'b1, 2'd0, 8'h00, 8'h00, 1'b1);
        tick();
        total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL clr_alone_sticky got=%b exp=0", err_sticky); end
`ifdef FF_BANK_ERRCNT_EN
        total++; if (err_count !== 2'd0) begin bad++; $display("FAIL clr_alone_cnt got=%0d exp=0", err_count); end
`endif
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 2'd3, 8'hFF, 8'h00, 1'b0);
        tick(); tick();
        #2 reset_n = 1'b0;
        m_q = INIT; m_ill = '0; m_sticky = 1'b0; m_cnt = 0;
        #1;
        total++; if (q !== INIT) begin bad++; $display("FAIL mid_reset_q got=%h exp=%h", q, INIT); end
        tick(); tick();
        total++; if (q !== INIT) begin bad++; $display("FAIL mid_reset_held got=%h exp=%h", q, INIT); end
        #2 reset_n = 1'b1;
        tick();
        total++; if (q !== ~INIT) begin bad++; $display("FAIL mid_reset_resume got=%h exp=%h", q, ~INIT); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            drive(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
                  8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
            tick();
            total++; if (q !== m_q) begin bad++; $display("FAIL rnd_q_%0d got=%h exp=%h", k, q, m_q); end
            total++; if (q_bar !== ~m_q) begin bad++; $display("FAIL rnd_q_bar_%0d got=%h exp=%h", k, q_bar, ~m_q); end
            total++; if (illegal !== m_ill) begin bad++; $display("FAIL rnd_ill_%0d got=%h exp=%h", k, illegal, m_ill); end
            total++; if (err_sticky !== m_sticky) begin bad++; $display("FAIL rnd_sticky_%0d got=%b exp=%b", k, err_sticky, m_sticky); end
`ifdef FF_BANK_ERRCNT_EN
            total++; if (int'(err_count) !== m_cnt) begin bad++; $display("FAIL rnd_cnt_%0d got=%0d exp=%0d", k, err_count, m_cnt); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_rs();
        test_toggle();
        test_enable_d();
        test_counter();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
